alu_txn_monitor: RTL and testbench
==================================

Name: alu_txn_monitor

Overview:
- Hardware transaction monitor sitting directly upstream of the ALU scoreboard.
- Observes the ALU issue interface (operands, opcode, signed flag) and the ALU result interface (result, flags).
- Pairs each result with its issuing operation in order, and presents complete transactions to the scoreboard over a valid/ready stream.
- Buffers transactions so that the non-stalling ALU is never back-pressured; overflow and protocol violations are flagged.

Parameters:
- WIDTH, 32, operand and result width
- OPW, 4, opcode width
- PEND_DEPTH, 8, issued-but-unresolved operation FIFO depth (power of 2, ≥2)
- OUT_DEPTH, 4, completed-transaction FIFO depth (power of 2, ≥2)
- TIMEOUT, 64, max cycles an op may stay pending (used only with ALU_MON_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  ALU accepted an operation this cycle
- op_opcode  in  OPW  issued opcode
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- op_signed  in  1  signed operation
- res_valid  in  1  ALU produced a result this cycle
- res_data  in  WIDTH  result
- res_flags  in  4  {zero,carry,overflow,negative}, bit3=zero … bit0=negative
- txn_valid  out  1  transaction available to scoreboard
- txn_ready  in  1  scoreboard accepts
- txn_id  out  32  transaction sequence number
- txn_opcode  out  OPW  opcode
- txn_a  out  WIDTH  operand A
- txn_b  out  WIDTH  operand B
- txn_signed  out  1  signed flag
- txn_result  out  WIDTH  actual result
- txn_flags  out  4  actual flags
- pend_count  out  $clog2(PEND_DEPTH)+1  current pending-op occupancy
- err_orphan  out  1  sticky: result seen with no pending op
- err_pend_ovf  out  1  sticky: op issued while pending FIFO full
- err_out_ovf  out  1  sticky: result completed while output FIFO full
- err_clear  in  1  synchronous clear of all sticky error bits and timeout state

Behaviour:
- Reset: both FIFOs empty; txn_valid=0; txn_id=0; pend_count=0; all err_* = 0; all txn_* data outputs = 0.
- Pending FIFO: op_valid pushes {opcode,a,b,signed}. If the FIFO is full and no pop occurs in the same cycle, the op is dropped and err_pend_ovf is set.
- Result pairing: res_valid pops the pending head and forms a transaction with res_data/res_flags.
  - The ALU latency is ≥1 cycle, so a result never pairs with an op issued in the same cycle.
  - res_valid while the pending FIFO is empty sets err_orphan and discards the result, even if op_valid is high that cycle.
- Simultaneous push and pop on a non-empty pending FIFO (including full) succeeds; occupancy is unchanged.
- Output FIFO: a formed transaction is pushed into the output FIFO.
  - If the output FIFO is full and no pop occurs that cycle, the transaction is dropped, its pending entry is still consumed, and err_out_ovf is set.
  - Simultaneous push and pop when full is legal.
- Stream rules:
  - txn_valid = output FIFO non-empty. A transfer occurs when txn_valid && txn_ready.
  - txn_* fields present the head entry and are stable while txn_valid && !txn_ready.
  - Latency is res_valid at cycle t → txn_valid at t+1 when the output FIFO was empty (registered, no combinational path from res_* to txn_*).
- txn_id: assigned at push into the output FIFO from a 32-bit counter that starts at 0, increments per pushed transaction, and wraps 0xFFFF_FFFF→0. Dropped transactions do not consume an id.
- Error bits are sticky until err_clear or reset. If err_clear and a new error occur in the same cycle, the error wins.
- Asynchronous reset mid-operation empties both FIFOs immediately; in-flight ALU results arriving after reset deassertion are reported as orphans.

Optional Feature:
- ALU_MON_TIMEOUT_EN defined:
  - An age counter tracks the pending head and restarts on every pop or when the FIFO becomes non-empty.
  - When the age reaches TIMEOUT, sticky output err_timeout (1 bit, reset 0, cleared by err_clear) is set and the head entry is discarded.
- Not defined: no err_timeout port, no counter; pending ops wait indefinitely.

Test Plan:
- Reset, then op(ADD, a=5, b=3) at cycle 1, res(8, flags=0000) at cycle 3, txn_ready=1 → txn_valid at cycle 4 with id=0, a=5, b=3, result=8; pend_count returns to 0.
- 8 back-to-back ops, results 1 cycle later each, txn_ready=0 for 10 cycles → output holds 4, next 4 results dropped, err_out_ovf=1; after ready, ids 0..3 are emitted in order.
- 9 ops with no results (PEND_DEPTH=8) → pend_count=8 and err_pend_ovf=1; the 9th op is never paired.
- res_valid with an empty pending FIFO and op_valid in the same cycle → err_orphan=1, no txn; pend_count=1.
- txn_id preset via force to 0xFFFF_FFFF, two transactions → ids 0xFFFF_FFFF then 0x0000_0000.
- With ALU_MON_TIMEOUT_EN and TIMEOUT=16: op with no result → err_timeout=1 at cycle 16 after the push, pend_count=0; err_clear clears it.

Source files
------------

// File: rtl/alu_txn_monitor.sv
// rtl/alu_txn_monitor.sv - pairs ALU issue/result events and streams complete transactions
// Optional feature macro: ALU_MON_TIMEOUT_EN (adds err_timeout and pending-head age-out)
module alu_txn_monitor #(
  parameter int WIDTH      = 32,
  parameter int OPW        = 4,
  parameter int PEND_DEPTH = 8,
  parameter int OUT_DEPTH  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          op_valid,
  input  logic [OPW-1:0]                op_opcode,
  input  logic [WIDTH-1:0]              op_a,
  input  logic [WIDTH-1:0]              op_b,
  input  logic                          op_signed,
  input  logic                          res_valid,
  input  logic [WIDTH-1:0]              res_data,
  input  logic [3:0]                    res_flags,
  output logic                          txn_valid,
  input  logic                          txn_ready,
  output logic [31:0]                   txn_id,
  output logic [OPW-1:0]                txn_opcode,
  output logic [WIDTH-1:0]              txn_a,
  output logic [WIDTH-1:0]              txn_b,
  output logic                          txn_signed,
  output logic [WIDTH-1:0]              txn_result,
  output logic [3:0]                    txn_flags,
  output logic [$clog2(PEND_DEPTH):0]   pend_count,
  output logic                          err_orphan,
  output logic                          err_pend_ovf,
  output logic                          err_out_ovf,
`ifdef ALU_MON_TIMEOUT_EN
  output logic                          err_timeout,
`endif
  input  logic                          err_clear
);

  localparam int PAW = $clog2(PEND_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [PAW:0] PEND_FULL = (PAW+1)'(PEND_DEPTH);
  localparam logic [OAW:0] OUT_FULL  = (OAW+1)'(OUT_DEPTH);

  // Issued-but-unresolved operations
  logic [OPW-1:0]   pend_opcode [PEND_DEPTH];
  logic [WIDTH-1:0] pend_a      [PEND_DEPTH];
  logic [WIDTH-1:0] pend_b      [PEND_DEPTH];
  logic             pend_signed [PEND_DEPTH];
  logic [PAW-1:0]   pend_wr;
  logic [PAW-1:0]   pend_rd;

  // Completed transactions waiting for the scoreboard
  logic [31:0]      out_id      [OUT_DEPTH];
  logic [OPW-1:0]   out_opcode  [OUT_DEPTH];
  logic [WIDTH-1:0] out_a       [OUT_DEPTH];
  logic [WIDTH-1:0] out_b       [OUT_DEPTH];
  logic             out_signed  [OUT_DEPTH];
  logic [WIDTH-1:0] out_result  [OUT_DEPTH];
  logic [3:0]       out_flags   [OUT_DEPTH];
  logic [OAW-1:0]   out_wr;
  logic [OAW-1:0]   out_rd;
  logic [OAW:0]     out_count;
  logic [31:0]      id_ctr;

  logic pend_empty;
  logic pend_full;
  logic res_pop;
  logic timeout_pop;
  logic pend_pop;
  logic pend_push;
  logic orphan;
  logic pend_ovf;
  logic out_full;
  logic out_pop;
  logic out_push;
  logic out_ovf;

  // Pairing decisions use pre-edge occupancy, so a result can never pair with
  // an op issued in the same cycle and an orphan is flagged even if op_valid is high.
  assign pend_empty = (pend_count == '0);
  assign pend_full  = (pend_count == PEND_FULL);
  assign res_pop    = res_valid && !pend_empty;
  assign orphan     = res_valid && pend_empty;
  assign pend_pop   = res_pop || timeout_pop;
  assign pend_push  = op_valid && (!pend_full || pend_pop);
  assign pend_ovf   = op_valid && pend_full && !pend_pop;

  assign out_full   = (out_count == OUT_FULL);
  assign out_pop    = txn_valid && txn_ready;
  assign out_push   = res_pop && (!out_full || out_pop);
  assign out_ovf    = res_pop && out_full && !out_pop;

  assign txn_valid  = (out_count != '0);
  assign txn_id     = out_id[out_rd];
  assign txn_opcode = out_opcode[out_rd];
  assign txn_a      = out_a[out_rd];
  assign txn_b      = out_b[out_rd];
  assign txn_signed = out_signed[out_rd];
  assign txn_result = out_result[out_rd];
  assign txn_flags  = out_flags[out_rd];

`ifdef ALU_MON_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT + 1);
  logic [AGE_W-1:0] pend_age;

  // Head is discarded on the cycle its age hits TIMEOUT unless a result claims it first
  assign timeout_pop = !pend_empty && !res_pop && (pend_age == AGE_W'(TIMEOUT - 1));

  // Age of the pending head; restarts whenever the head changes or the FIFO is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_age    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (pend_empty || pend_pop) pend_age <= '0;
      else                        pend_age <= pend_age + 1'b1;
      if (timeout_pop)    err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;
    end
  end
`else
  assign timeout_pop = 1'b0;
  // TIMEOUT only has meaning when the age-out logic is compiled in
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // Pending FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_wr    <= '0;
      pend_rd    <= '0;
      pend_count <= '0;
    end else begin
      if (pend_push) pend_wr <= pend_wr + 1'b1;
      if (pend_pop)  pend_rd <= pend_rd + 1'b1;
      case ({pend_push, pend_pop})
        2'b10:   pend_count <= pend_count + 1'b1;
        2'b01:   pend_count <= pend_count - 1'b1;
        default: pend_count <= pend_count;
      endcase
    end
  end

  // Pending FIFO storage; contents are only meaningful below pend_count
  always_ff @(posedge clk) begin
    if (pend_push) begin
      pend_opcode[pend_wr] <= op_opcode;
      pend_a[pend_wr]      <= op_a;
      pend_b[pend_wr]      <= op_b;
      pend_signed[pend_wr] <= op_signed;
    end
  end

  // Output FIFO: storage is reset so txn_* fields read zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        out_id[i]     <= '0;
        out_opcode[i] <= '0;
        out_a[i]      <= '0;
        out_b[i]      <= '0;
        out_signed[i] <= 1'b0;
        out_result[i] <= '0;
        out_flags[i]  <= '0;
      end
      out_wr    <= '0;
      out_rd    <= '0;
      out_count <= '0;
      id_ctr    <= '0;
    end else begin
      if (out_push) begin
        out_id[out_wr]     <= id_ctr;
        out_opcode[out_wr] <= pend_opcode[pend_rd];
        out_a[out_wr]      <= pend_a[pend_rd];
        out_b[out_wr]      <= pend_b[pend_rd];
        out_signed[out_wr] <= pend_signed[pend_rd];
        out_result[out_wr] <= res_data;
        out_flags[out_wr]  <= res_flags;
        out_wr             <= out_wr + 1'b1;
        id_ctr             <= id_ctr + 1'b1;
      end
      if (out_pop) out_rd <= out_rd + 1'b1;
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + 1'b1;
        2'b01:   out_count <= out_count - 1'b1;
        default: out_count <= out_count;
      endcase
    end
  end

  // Sticky error bits; a new error in the same cycle as err_clear stays set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_orphan   <= 1'b0;
      err_pend_ovf <= 1'b0;
      err_out_ovf  <= 1'b0;
    end else begin
      if (orphan)         err_orphan   <= 1'b1;
      else if (err_clear) err_orphan   <= 1'b0;
      if (pend_ovf)       err_pend_ovf <= 1'b1;
      else if (err_clear) err_pend_ovf <= 1'b0;
      if (out_ovf)        err_out_ovf  <= 1'b1;
      else if (err_clear) err_out_ovf  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_txn_monitor.sv
// tb/tb_alu_txn_monitor.sv - scoreboard bench for alu_txn_monitor
module tb_alu_txn_monitor;

  localparam int WIDTH      = 32;
  localparam int OPW        = 4;
  localparam int PEND_DEPTH = 8;
  localparam int OUT_DEPTH  = 4;

  logic             clk;
  logic             rst_n;
  logic             op_valid;
  logic [OPW-1:0]   op_opcode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_signed;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic [3:0]       res_flags;
  logic             txn_valid;
  logic             txn_ready;
  logic [31:0]      txn_id;
  logic [OPW-1:0]   txn_opcode;
  logic [WIDTH-1:0] txn_a;
  logic [WIDTH-1:0] txn_b;
  logic             txn_signed;
  logic [WIDTH-1:0] txn_result;
  logic [3:0]       txn_flags;
  logic [3:0]       pend_count;
  logic             err_orphan;
  logic             err_pend_ovf;
  logic             err_out_ovf;
`ifdef ALU_MON_TIMEOUT_EN
  logic             err_timeout;
`endif
  logic             err_clear;

  alu_txn_monitor #(
    .WIDTH(WIDTH), .OPW(OPW), .PEND_DEPTH(PEND_DEPTH), .OUT_DEPTH(OUT_DEPTH), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_opcode(op_opcode), .op_a(op_a), .op_b(op_b), .op_signed(op_signed),
    .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_id(txn_id), .txn_opcode(txn_opcode),
    .txn_a(txn_a), .txn_b(txn_b), .txn_signed(txn_signed), .txn_result(txn_result),
    .txn_flags(txn_flags), .pend_count(pend_count),
    .err_orphan(err_orphan), .err_pend_ovf(err_pend_ovf), .err_out_ovf(err_out_ovf),
`ifdef ALU_MON_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .err_clear(err_clear)
  );

  typedef struct {
    logic [OPW-1:0]   opc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sg;
  } op_t;

  typedef struct {
    logic [31:0]      id;
    logic [OPW-1:0]   opc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sg;
    logic [WIDTH-1:0] res;
    logic [3:0]       fl;
  } txn_t;

  // Reference model state: what the monitor should hold after the latest edge
  op_t         pq[$];
  txn_t        exp_q[$];
  int          out_cnt;
  logic [31:0] m_id;
  logic        m_orphan, m_pend_ovf, m_out_ovf;

  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    exp_q.delete();
    out_cnt    = 0;
    m_id       = '0;
    m_orphan   = 1'b0;
    m_pend_ovf = 1'b0;
    m_out_ovf  = 1'b0;
  endtask

  // One clock edge of the monitor's documented behaviour, from current inputs
  task automatic model_step();
    bit   opop, e_orph, e_pov, e_oov;
    op_t  o;
    txn_t t;
    opop   = (out_cnt > 0) && txn_ready;
    e_orph = 0; e_pov = 0; e_oov = 0;
    if (res_valid) begin
      if (pq.size() == 0) e_orph = 1;
      else begin
        o = pq.pop_front();
        if (out_cnt < OUT_DEPTH || opop) begin
          t.id = m_id; t.opc = o.opc; t.a = o.a; t.b = o.b; t.sg = o.sg;
          t.res = res_data; t.fl = res_flags;
          exp_q.push_back(t);
          m_id = m_id + 1;
          out_cnt++;
        end else e_oov = 1;
      end
    end
    if (opop) out_cnt--;
    if (op_valid) begin
      if (pq.size() < PEND_DEPTH) begin
        o.opc = op_opcode; o.a = op_a; o.b = op_b; o.sg = op_signed;
        pq.push_back(o);
      end else e_pov = 1;
    end
    m_orphan   = e_orph ? 1'b1 : (err_clear ? 1'b0 : m_orphan);
    m_pend_ovf = e_pov  ? 1'b1 : (err_clear ? 1'b0 : m_pend_ovf);
    m_out_ovf  = e_oov  ? 1'b1 : (err_clear ? 1'b0 : m_out_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    op_valid  = 1'b0;
    res_valid = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic set_op(input logic [OPW-1:0] opc, input logic [31:0] a, input logic [31:0] b, input logic sg);
    op_valid = 1'b1; op_opcode = opc; op_a = a; op_b = b; op_signed = sg;
  endtask

  task automatic set_res(input logic [31:0] d, input logic [3:0] f);
    res_valid = 1'b1; res_data = d; res_flags = f;
  endtask

  task automatic do_reset();
    op_valid = 1'b0; res_valid = 1'b0; err_clear = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares state every cycle and pops the scoreboard on each transfer
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      chk("txn_valid", txn_valid, out_cnt > 0);
      chk("pend_count", pend_count, pq.size());
      chk("err_orphan", err_orphan, m_orphan);
      chk("err_pend_ovf", err_pend_ovf, m_pend_ovf);
      chk("err_out_ovf", err_out_ovf, m_out_ovf);
      if (txn_valid && txn_ready) begin
        if (exp_q.size() == 0) chk("unexpected_txn", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("txn_id", txn_id, e.id);
          chk("txn_opcode", txn_opcode, e.opc);
          chk("txn_a", txn_a, e.a);
          chk("txn_b", txn_b, e.b);
          chk("txn_signed", txn_signed, e.sg);
          chk("txn_result", txn_result, e.res);
          chk("txn_flags", txn_flags, e.fl);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_opcode = '0; op_a = '0; op_b = '0; op_signed = 1'b0;
    res_valid = 1'b0; res_data = '0; res_flags = '0; txn_ready = 1'b1; err_clear = 1'b0;
    model_reset();

    // Reset values
    @(negedge clk);
    chk("rst_txn_valid", txn_valid, 0);
    chk("rst_txn_id", txn_id, 0);
    chk("rst_txn_a", txn_a, 0);
    chk("rst_txn_result", txn_result, 0);
    chk("rst_pend_count", pend_count, 0);
    chk("rst_errs", {err_orphan, err_pend_ovf, err_out_ovf}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single ADD transaction, result two cycles after issue
    txn_ready = 1'b1;
    tick();
    set_op(4'h0, 5, 3, 1'b0); tick();
    tick();
    set_res(8, 4'b0000); tick();
    chk("add_valid_next_cycle", txn_valid, 1);
    chk("add_id", txn_id, 0);
    chk("add_a", txn_a, 5);
    chk("add_b", txn_b, 3);
    chk("add_result", txn_result, 8);
    chk("add_pend_zero", pend_count, 0);
    tick();

    // Output overflow: 8 results while the scoreboard stalls
    do_reset();
    txn_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_op(4'(i), i, 2 * i, 1'b0);
      if (i >= 1 && i <= 8) set_res(100 * i, 4'(i));
      tick();
    end
    chk("ovf_out_err", err_out_ovf, 1);
    chk("ovf_head_id", txn_id, 0);
    chk("ovf_pend_zero", pend_count, 0);
    txn_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("ovf_drained", txn_valid, 0);
    err_clear = 1'b1; tick();
    chk("ovf_cleared", err_out_ovf, 0);

    // Pending overflow: 9 ops, no results
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_op(4'(i), 32'h1000 + i, i, 1'(i));
      tick();
    end
    chk("povf_count", pend_count, 8);
    chk("povf_err", err_pend_ovf, 1);
    for (int i = 0; i < 8; i++) begin
      set_res(32'hA0 + i, 4'(15 - i));
      tick();
    end
    tick(); tick();
    chk("povf_empty", pend_count, 0);

    // Orphan result coinciding with a new op
    do_reset();
    set_op(4'h3, 7, 9, 1'b1);
    set_res(32'hDEAD, 4'b1000);
    tick();
    chk("orph_err", err_orphan, 1);
    chk("orph_count", pend_count, 1);
    chk("orph_no_txn", txn_valid, 0);
    set_res(16, 4'b0000); tick();
    tick();

    // Id wrap
    do_reset();
    force dut.id_ctr = 32'hFFFF_FFFF;
    tick();
    release dut.id_ctr;
    m_id = 32'hFFFF_FFFF;
    set_op(4'h1, 1, 2, 1'b0); tick();
    set_op(4'h2, 3, 4, 1'b0); tick();
    set_res(3, 4'b0000); tick();
    chk("wrap_id_first", txn_id, 32'hFFFF_FFFF);
    set_res(7, 4'b0000); tick();
    chk("wrap_id_second", txn_id, 32'h0000_0000);
    tick(); tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1) set_op(4'($urandom), $urandom, $urandom, 1'($urandom));
      if ($urandom_range(0, 15) == 0 || (pq.size() > 0 && $urandom_range(0, 2) != 0))
        set_res($urandom, 4'($urandom));
      txn_ready = ($urandom_range(0, 3) != 0);
      err_clear = ($urandom_range(0, 31) == 0);
      tick();
    end

    // Asynchronous reset with work in flight
    txn_ready = 1'b0;
    set_op(4'h5, 1, 1, 1'b0); tick();
    set_op(4'h6, 2, 2, 1'b0); tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_pend_zero", pend_count, 0);
    chk("async_txn_valid", txn_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_res(32'h55, 4'b0001); tick();
    chk("async_late_orphan", err_orphan, 1);

    // Drain
    txn_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
